ddr_beat_ctrl: RTL

DDR_BEAT_CTRL -- requirements
Module: ddr_beat_ctrl

---
 rtl/ddr_beat_ctrl_pkg.sv | 36 +++
 rtl/ddr_beat_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ddr_beat_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ddr_beat_ctrl_pkg
// Shared definitions for the DDR line-to-beat controller: the FSM state
// encoding, the beat counter width and the helper that forms the backing
// memory address of one beat.
// ---------------------------------------------------------------------------
package ddr_beat_ctrl_pkg;

    // Controller states: waiting for a core request, presenting a beat to the
    // backing memory, waiting for read data of the current beat, and the
    // single-cycle completion state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } beatState_e;

    // The beat counter is three bits wide; a full 512-bit line has eight beats.
    localparam int CNT_W = 3;

    // A burst walks the eight 8-byte beats of the 64-byte aligned line in
    // ascending order; a single beat just drops the byte offset.
    function automatic logic [63:0] beatAddr(input logic [63:3] index,
                                             input logic [2:0]  beat,
                                             input logic        burst);
        logic [63:0] addr;
        if (burst) begin
            addr = {index[63:6], beat, 3'b000};
        end else begin
            addr = {index[63:3], 3'b000};
        end
        return addr;
    endfunction

endpackage

// File: rtl/ddr_beat_ctrl.sv
// ---------------------------------------------------------------------------
// ddr_beat_ctrl
// Converts one core DDR-channel request (a single 64-bit beat or a full
// 512-bit line) into a sequence of 64-bit requests on a valid/ready backing
// memory port, gathering read beats back into a 512-bit line.
//
// Ports
//   clock, reset_n          : single clock, synchronous active-low reset
//   ddr_chip_enable         : core request strobe, honoured only while idle
//   ddr_index               : byte address of the request
//   ddr_write_enable        : 1 = write, 0 = read
//   ddr_burst_mode          : 1 = whole line (BEATS beats), 0 = one beat
//   ddr_write_mask/_data    : per-bit write mask and write data for the line
//   ddr_read_data           : assembled read line
//   ddr_operation_done      : one-cycle completion pulse
//   ddr_ready               : high while a new request can be accepted
//   mem_req_valid/_ready    : beat request handshake to the backing memory
//   mem_addr/we/wdata/wmask : beat request payload
//   mem_rvalid/mem_rdata    : read data return from the backing memory
// ---------------------------------------------------------------------------
module ddr_beat_ctrl
    import ddr_beat_ctrl_pkg::*;
#(
    parameter int BEATS  = 8,
    parameter int BEAT_W = 64
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    ddr_chip_enable,
    input  logic [63:0]             ddr_index,
    input  logic                    ddr_write_enable,
    input  logic                    ddr_burst_mode,
    input  logic [BEATS*BEAT_W-1:0] ddr_write_mask,
    input  logic [BEATS*BEAT_W-1:0] ddr_write_data,
    output logic [BEATS*BEAT_W-1:0] ddr_read_data,
    output logic                    ddr_operation_done,
    output logic                    ddr_ready,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [63:0]             mem_addr,
    output logic                    mem_we,
    output logic [BEAT_W-1:0]       mem_wdata,
    output logic [BEAT_W-1:0]       mem_wmask,
    input  logic                    mem_rvalid,
    input  logic [BEAT_W-1:0]       mem_rdata
);

    localparam int LINE_W = BEATS * BEAT_W;

    beatState_e        state_q, state_d;
    logic [63:3]       index_q, index_d;
    logic              we_q, we_d;
    logic              burst_q, burst_d;
    logic [LINE_W-1:0] mask_q, mask_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              lastBeat;
    int                sliceLo;

    // Beat addresses are always 8-byte aligned, so the low index bits are
    // never needed once a request is latched.
    logic unusedIndexBits;
    assign unusedIndexBits = ^ddr_index[2:0];

    // Bit offset of the current beat inside the latched line; a single-beat
    // request keeps the counter at zero and therefore uses slice [63:0].
    assign sliceLo  = int'(beat_q) * BEAT_W;
    assign lastBeat = !burst_q || (beat_q == CNT_W'(BEATS - 1));

    // State register and request latches; reset abandons any transaction in
    // flight, so no completion pulse can follow it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            index_q <= '0;
            we_q    <= 1'b0;
            burst_q <= 1'b0;
            mask_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            we_q    <= we_d;
            burst_q <= burst_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state logic. A request is latched only in IDLE, so strobes that
    // arrive while a transaction is running are simply dropped. Writes move
    // to the next beat directly on the handshake; reads detour through
    // WAIT_R until the memory returns the beat. Read data is cleared on
    // accept and then held until the next accept.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        we_d    = we_q;
        burst_d = burst_q;
        mask_d  = mask_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        beat_d  = beat_q;

        unique case (state_q)
            IDLE: begin
                if (ddr_chip_enable) begin
                    index_d = ddr_index[63:3];
                    we_d    = ddr_write_enable;
                    burst_d = ddr_burst_mode;
                    mask_d  = ddr_write_mask;
                    data_d  = ddr_write_data;
                    rdata_d = '0;
                    beat_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    if (we_q) begin
                        if (lastBeat) begin
                            state_d = DONE;
                        end else begin
                            beat_d = beat_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    rdata_d[sliceLo +: BEAT_W] = mem_rdata;
                    if (lastBeat) begin
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + CNT_W'(1);
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                beat_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Beat payload comes straight from the latched request, so it stays
    // stable for as long as the memory holds off the handshake.
    assign ddr_ready          = (state_q == IDLE);
    assign ddr_operation_done = (state_q == DONE);
    assign mem_req_valid      = (state_q == REQ);
    assign mem_we             = (state_q == REQ) && we_q;
    assign mem_addr           = beatAddr(index_q, beat_q, burst_q);
    assign mem_wdata          = data_q[sliceLo +: BEAT_W];
    assign mem_wmask          = mask_q[sliceLo +: BEAT_W];
    assign ddr_read_data      = rdata_q;

endmodule
